regfile_scoreboard: RTL and testbench

//  Parametrised general-purpose register file for the decode/writeback stages. It succeeds the fixed 32x32 file.
//  - NRD registered read ports, with write-through bypass.
//  - One write port; register 0 is hardwired to zero.
//  - Per-register busy scoreboard, so decode can stall on RAW hazards from in-flight producers.
//  - Debug tap of one register onto LED.

---
 rtl/regfile_pkg.sv | 19 +
 rtl/regfile_read_port.sv | 37 +++
 rtl/regfile_scoreboard.sv | 94 +++++++++
 tb/tb_regfile_scoreboard.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared sizing helpers and types for the register file / scoreboard.
package regfile_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;

  // Address width for a register count; a 1-register file still needs one bit.
  function automatic int aw_of(input int nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

  localparam int AW = aw_of(NREG_DEF);

  typedef logic [AW-1:0]       reg_addr_t;
  typedef logic [XLEN_DEF-1:0] reg_data_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: zero-register and same-cycle writeback bypass
// in front of the RD output flop.
module regfile_read_port #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            RE,
  input  logic [AW-1:0]   RA,
  input  logic            WE,
  input  logic [AW-1:0]   WA,
  input  logic [XLEN-1:0] WB,
  input  logic [XLEN-1:0] RWORD,
  output logic [XLEN-1:0] RD
);

  logic [XLEN-1:0] rd_nxt;

  // Register 0 reads as zero; a write landing this edge is forwarded.
  always_comb begin
    rd_nxt = RWORD;
    if (RA == '0)
      rd_nxt = '0;
    else if (WE && (WA == RA))
      rd_nxt = WB;
  end

  // Capture on the read strobe, otherwise hold.
  always_ff @(posedge CLK) begin
    if (RST)
      RD <= '0;
    else if (RE)
      RD <= rd_nxt;
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Parametrised register file with per-register busy scoreboard,
// NRD bypassed read ports, one write port and an LED debug tap.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int NREG    = NREG_DEF,
  parameter int NRD     = 2,
  parameter int DBG_REG = 2,
  parameter int DBG_W   = 8,
  localparam int AW     = aw_of(NREG)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     RE,
  input  logic [NRD-1:0][AW-1:0]   RA,
  output logic [NRD-1:0][XLEN-1:0] RD,
  output logic                     HAZARD,
  input  logic                     ISSUE,
  input  logic [AW-1:0]            ISSUE_RD,
  input  logic                     WE,
  input  logic [AW-1:0]            WA,
  input  logic [XLEN-1:0]          WB,
  output logic [NREG-1:0]          BUSY_VEC,
  output logic [DBG_W-1:0]         LED
);

  logic [NREG-1:0][XLEN-1:0] regs;
  logic [NREG-1:0]           busy;
  logic [NREG-1:0]           busy_nxt;
  logic                      wr_en;

  assign wr_en = WE && (WA != '0);

  // Flop-based storage; slot 0 is never written so it stays zero.
  always_ff @(posedge CLK) begin
    if (RST)
      regs <= '0;
    else if (wr_en)
      regs[WA] <= WB;
  end

  // Scoreboard next state: a new producer outranks a retiring one.
  always_comb begin
    busy_nxt = busy;
    for (int r = 1; r < NREG; r++) begin
      if (ISSUE && (ISSUE_RD == AW'(r)))
        busy_nxt[r] = 1'b1;
      else if (WE && (WA == AW'(r)))
        busy_nxt[r] = 1'b0;
    end
    busy_nxt[0] = 1'b0;
  end

  // Scoreboard state; reset drops every in-flight mark.
  always_ff @(posedge CLK) begin
    if (RST)
      busy <= '0;
    else
      busy <= busy_nxt;
  end

  assign BUSY_VEC = busy;

  // Stall when any source waits on a producer that is not retiring now.
  always_comb begin
    HAZARD = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      if ((RA[i] != '0) && busy[RA[i]] && !(WE && (WA == RA[i])))
        HAZARD = 1'b1;
    end
  end

  // Debug tap straight off the storage flop, no write bypass.
  assign LED = regs[DBG_REG][DBG_W-1:0];

  for (genvar i = 0; i < NRD; i++) begin : g_rp
    regfile_read_port #(
      .XLEN (XLEN),
      .AW   (AW)
    ) u_rp (
      .CLK   (CLK),
      .RST   (RST),
      .RE    (RE),
      .RA    (RA[i]),
      .WE    (WE),
      .WA    (WA),
      .WB    (WB),
      .RWORD (regs[RA[i]]),
      .RD    (RD[i])
    );
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: two configurations side by side, each with
// directed cases pinned by literals plus randomized traffic against an
// array-based reference model, compared every negedge.
module tb_regfile_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_bad  = 0;
  int n_done = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic mark_done();
    n_done++;
  endtask

  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int XL  = (g == 0) ? 32 : 64;
    localparam int NR  = (g == 0) ? 32 : 16;
    localparam int ND  = (g == 0) ? 2  : 3;
    localparam int AWC = $clog2(NR);

    logic                   rst, re, issue, we;
    logic [ND-1:0][AWC-1:0] ra;
    logic [AWC-1:0]         ird, wa;
    logic [XL-1:0]          wb;
    logic [ND-1:0][XL-1:0]  rd;
    logic                   hazard;
    logic [NR-1:0]          busy_vec;
    logic [7:0]             led;
    logic                   chk_en = 1'b0;

    // reference state
    logic [XL-1:0] m_regs [NR];
    logic          m_busy [NR];
    logic [XL-1:0] m_rd   [ND];

    regfile_scoreboard #(
      .XLEN(XL), .NREG(NR), .NRD(ND), .DBG_REG(2), .DBG_W(8)
    ) dut (
      .CLK(clk), .RST(rst), .RE(re), .RA(ra), .RD(rd), .HAZARD(hazard),
      .ISSUE(issue), .ISSUE_RD(ird), .WE(we), .WA(wa), .WB(wb),
      .BUSY_VEC(busy_vec), .LED(led)
    );

    // Apply one clock edge worth of architectural effect to the model.
    task automatic model_edge();
      if (rst) begin
        for (int r = 0; r < NR; r++) begin m_regs[r] = '0; m_busy[r] = 1'b0; end
        for (int p = 0; p < ND; p++) m_rd[p] = '0;
      end else begin
        if (re)
          for (int p = 0; p < ND; p++)
            m_rd[p] = (ra[p] == 0) ? '0 : (we && wa == ra[p]) ? wb : m_regs[ra[p]];
        if (we && wa != 0) m_regs[wa] = wb;
        if (we) m_busy[wa] = 1'b0;
        if (issue && ird != 0) m_busy[ird] = 1'b1;
        m_busy[0] = 1'b0;
      end
    endtask

    task automatic step();
      @(posedge clk);
      model_edge();
      #1;
    endtask

    task automatic idle();
      rst = 1'b0; re = 1'b0; issue = 1'b0; we = 1'b0;
    endtask

    always @(negedge clk) begin : compare
      logic [NR-1:0] eb;
      logic          hz;
      if (chk_en) begin
        for (int p = 0; p < ND; p++)
          chk($sformatf("cfg%0d rd%0d", g, p), 64'(rd[p]), 64'(m_rd[p]));
        for (int r = 0; r < NR; r++) eb[r] = m_busy[r];
        chk($sformatf("cfg%0d busy_vec", g), 64'(busy_vec), 64'(eb));
        chk($sformatf("cfg%0d led", g), 64'(led), 64'(m_regs[2][7:0]));
        hz = 1'b0;
        for (int p = 0; p < ND; p++)
          if (ra[p] != 0 && m_busy[ra[p]] && !(we && wa == ra[p])) hz = 1'b1;
        chk($sformatf("cfg%0d hazard", g), 64'(hazard), 64'(hz));
      end
    end

    initial begin : stim
      idle();
      rst = 1'b1; ra = '0; ird = '0; wa = '0; wb = '0;
      step();
      chk_en = 1'b1;
      rst = 1'b0;

      // reset: fill the file and the scoreboard, then reset
      for (int i = 1; i < NR; i++) begin
        we = 1'b1; wa = AWC'(i); wb = XL'(i * 'h11);
        issue = 1'b1; ird = AWC'(NR - i);
        step();
      end
      idle();
      chk($sformatf("cfg%0d led_prefill", g), 64'(led), 64'h22);
      rst = 1'b1; we = 1'b1; wa = AWC'(3); wb = XL'('h77);
      step();
      idle();
      chk($sformatf("cfg%0d busy_after_rst", g), 64'(busy_vec), 64'h0);
      chk($sformatf("cfg%0d led_after_rst", g), 64'(led), 64'h0);
      re = 1'b1;
      for (int p = 0; p < ND; p++) ra[p] = AWC'(p + 3);
      step();
      idle();
      chk($sformatf("cfg%0d rd0_after_rst", g), 64'(rd[0]), 64'h0);

      // zero register
      we = 1'b1; wa = '0; wb = XL'('hDEADBEEF); issue = 1'b1; ird = '0;
      step();
      idle();
      chk($sformatf("cfg%0d busy0", g), 64'(busy_vec[0]), 64'h0);
      re = 1'b1; ra = '0;
      step();
      idle();
      chk($sformatf("cfg%0d rd_zero", g), 64'(rd[0]), 64'h0);

      // bypass
      we = 1'b1; wa = AWC'(6); wb = XL'('h66);
      step();
      we = 1'b1; wa = AWC'(5); wb = XL'('h12345678); re = 1'b1;
      for (int p = 0; p < ND; p++) ra[p] = AWC'(5);
      step();
      chk($sformatf("cfg%0d bypass_rd0", g), 64'(rd[0]), 64'h12345678);
      chk($sformatf("cfg%0d bypass_rd1", g), 64'(rd[1]), 64'h12345678);
      we = 1'b1; wa = AWC'(5); wb = XL'('hABC); ra[0] = AWC'(6);
      step();
      idle();
      chk($sformatf("cfg%0d old_reg6", g), 64'(rd[0]), 64'h66);

      // scoreboard set / release
      ra = '0;
      issue = 1'b1; ird = AWC'(7);
      step();
      idle();
      ra[0] = AWC'(7);
      #1 chk($sformatf("cfg%0d hazard_set", g), 64'(hazard), 64'h1);
      we = 1'b1; wa = AWC'(7); wb = XL'(1);
      #1 chk($sformatf("cfg%0d hazard_release", g), 64'(hazard), 64'h0);
      step();
      idle();
      chk($sformatf("cfg%0d busy7_clr", g), 64'(busy_vec[7]), 64'h0);

      // set and clear collide on the same register
      ra = '0;
      issue = 1'b1; ird = AWC'(9);
      step();
      issue = 1'b1; ird = AWC'(9); we = 1'b1; wa = AWC'(9); wb = XL'('hA5);
      step();
      idle();
      chk($sformatf("cfg%0d busy9_kept", g), 64'(busy_vec[9]), 64'h1);
      re = 1'b1; ra[0] = AWC'(9);
      #1 chk($sformatf("cfg%0d hazard9", g), 64'(hazard), 64'h1);
      step();
      idle();
      chk($sformatf("cfg%0d reg9", g), 64'(rd[0]), 64'hA5);

      // debug tap: not bypassed, visible after the edge
      ra = '0;
      we = 1'b1; wa = AWC'(2); wb = XL'('h1C3);
      #1 chk($sformatf("cfg%0d led_pre", g), 64'(led), 64'h0);
      step();
      idle();
      chk($sformatf("cfg%0d led_post", g), 64'(led), 64'hC3);

      // randomized traffic
      repeat (400) begin
        rst   = ($urandom_range(0, 49) == 0);
        re    = 1'($urandom);
        issue = ($urandom_range(0, 2) == 0);
        ird   = AWC'($urandom);
        we    = 1'($urandom);
        wa    = AWC'($urandom);
        wb    = XL'({$urandom, $urandom});
        for (int p = 0; p < ND; p++) ra[p] = AWC'($urandom);
        step();
      end
      idle();
      step();
      mark_done();
    end
  end

  initial begin : finisher
    int t;
    t = 0;
    while (n_done < 2 && t < 20000) begin
      @(posedge clk);
      t++;
    end
    if (n_done < 2) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: done %0d want 2", n_done);
    end
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
